timer_irq: RTL and testbench

Programmable countdown timer peripheral on the processor's memory-mapped device bus. Software loads a preset and a control word with plain word stores; the block counts down and raises an interrupt request, which feeds one bit of the coprocessor's six-bit hardware-interrupt input (HWInt). It supports two modes: one-shot with a held interrupt, and auto-reload with a one-cycle interrupt pulse.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/timer_irq.sv | 128 ++++++++++++
 tb/tb_timer_irq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer peripheral.
// Register offsets, CTRL bit positions, modes and FSM states.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  localparam logic [1:0] CTRL_OFF   = 2'd0;
  localparam logic [1:0] PRESET_OFF = 2'd1;
  localparam logic [1:0] COUNT_OFF  = 2'd2;

  localparam int EN      = 0;
  localparam int MODE_LO = 1;
  localparam int MODE_HI = 2;
  localparam int IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_irq.sv
// Memory-mapped countdown timer with one-shot (held irq)
// and auto-reload (one-cycle irq pulse) modes.
module timer_irq
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic             ctrl_we;
  logic             preset_we;
  logic             en;
  logic             im;
  logic [1:0]       mode;
  logic             reload;
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  state_t           state;
  state_t           state_nxt;
  logic             irq_flag;
  logic             flag_set;
  logic             en_clr;

  // Register file and write decode
  assign ctrl_we   = we && (addr == CTRL_OFF);
  assign preset_we = we && (addr == PRESET_OFF);
  assign reload    = (mode == MODE_RELOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en   <= 1'b0;
      mode <= MODE_ONESHOT;
      im   <= 1'b0;
    end else if (ctrl_we) begin
      en   <= wdata[EN];
      mode <= wdata[MODE_HI:MODE_LO];
      im   <= wdata[IM];
    end else if (en_clr) begin
      en <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset <= '0;
    end else if (preset_we) begin
      preset <= wdata[WIDTH-1:0];
    end
  end

  // FSM with the counter; it sees pre-write CTRL/PRESET
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    flag_set  = 1'b0;
    en_clr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) state_nxt = LOAD;
      end
      LOAD: begin
        count_nxt = preset;
        state_nxt = CNT;
      end
      CNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (count > WIDTH'(1)) begin
          count_nxt = count - WIDTH'(1);
        end else begin
          count_nxt = '0;
          state_nxt = INT;
        end
      end
      INT: begin
        flag_set  = 1'b1;
        en_clr    = !reload;
        state_nxt = IDLE;
      end
    endcase
    if (ctrl_we && !wdata[EN]) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // A CTRL write beats a same-cycle set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_flag <= 1'b0;
    end else if (ctrl_we) begin
      irq_flag <= 1'b0;
    end else if (flag_set) begin
      irq_flag <= 1'b1;
    end else if (reload) begin
      irq_flag <= 1'b0;
    end
  end

  // Read mux and irq
  always_comb begin
    rdata = '0;
    unique case (addr)
      CTRL_OFF:   rdata[3:0] = {im, mode, en};
      PRESET_OFF: rdata = 32'(preset);
      COUNT_OFF:  rdata = 32'(count);
      default:    rdata = '0;
    endcase
  end

  assign irq = irq_flag & im;

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: register vector table
// plus hand-written multi-cycle sequences.
module tb_timer_irq;
  import timer_pkg::*;

  typedef struct {
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  vec_t tbl [9];

  timer_irq #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .we(we),
    .wdata(wdata),
    .rdata(rdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic rdc(input string name, input logic [1:0] a,
                     input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    tbl[0] = '{1'b0, CTRL_OFF,   32'h0,        CTRL_OFF,   32'h0};
    tbl[1] = '{1'b0, CTRL_OFF,   32'h0,        PRESET_OFF, 32'h0};
    tbl[2] = '{1'b0, CTRL_OFF,   32'h0,        COUNT_OFF,  32'h0};
    tbl[3] = '{1'b1, PRESET_OFF, 32'h12345678, PRESET_OFF, 32'h12345678};
    tbl[4] = '{1'b1, COUNT_OFF,  32'h0000dead, COUNT_OFF,  32'h0};
    tbl[5] = '{1'b1, CTRL_OFF,   32'hfffffff6, CTRL_OFF,   32'h6};
    tbl[6] = '{1'b0, CTRL_OFF,   32'h0,        2'd3,       32'h0};
    tbl[7] = '{1'b1, 2'd3,       32'hffffffff, 2'd3,       32'h0};
    tbl[8] = '{1'b1, CTRL_OFF,   32'h0,        CTRL_OFF,   32'h0};

    // reset state while reset is held low
    #2;
    check("rst irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++)
      rdc($sformatf("rst rdata%0d", a), 2'(a), 32'd0);
    reset = 1'b1;
    tick();

    // register vectors (en stays 0 throughout)
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].we) wr(tbl[i].waddr, tbl[i].wdata);
      else tick();
      rdc($sformatf("vec%0d rdata", i), tbl[i].raddr, tbl[i].exp);
      check($sformatf("vec%0d irq", i), {31'd0, irq}, 32'd0);
    end

    // one-shot, PRESET = 5
    do_reset();
    wr(PRESET_OFF, 32'd5);
    wr(CTRL_OFF, 32'h9);
    tick(2);
    for (int k = 0; k < 6; k++) begin
      rdc($sformatf("oneshot count E%0d", k + 2), COUNT_OFF,
          32'(5 - k));
      check($sformatf("oneshot irq E%0d", k + 2), {31'd0, irq}, 32'd0);
      tick();
    end
    check("oneshot irq E8", {31'd0, irq}, 32'd1);
    rdc("oneshot ctrl", CTRL_OFF, 32'h8);
    tick();
    check("oneshot irq held", {31'd0, irq}, 32'd1);
    wr(CTRL_OFF, 32'h8);
    check("oneshot irq clr", {31'd0, irq}, 32'd0);

    // auto-reload, PRESET = 3: pulse at E6, E12, E18, E24
    do_reset();
    wr(PRESET_OFF, 32'd3);
    wr(CTRL_OFF, 32'hB);
    for (int e = 1; e <= 25; e++) begin
      tick();
      check($sformatf("reload irq E%0d", e), {31'd0, irq},
            {31'd0, (e >= 6 && e % 6 == 0)});
    end
    rdc("reload ctrl", CTRL_OFF, 32'hB);

    // masked one-shot, PRESET = 2
    do_reset();
    wr(PRESET_OFF, 32'd2);
    wr(CTRL_OFF, 32'h1);
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("mask irq E%0d", e), {31'd0, irq}, 32'd0);
    end
    rdc("mask ctrl", CTRL_OFF, 32'h0);
    wr(CTRL_OFF, 32'h8);
    check("mask unmask irq", {31'd0, irq}, 32'd0);
    tick();
    check("mask unmask irq2", {31'd0, irq}, 32'd0);

    // disable mid-count, PRESET = 10
    do_reset();
    wr(PRESET_OFF, 32'd10);
    wr(CTRL_OFF, 32'h9);
    tick(2);
    rdc("dis count E2", COUNT_OFF, 32'd10);
    tick(4);
    rdc("dis count E6", COUNT_OFF, 32'd6);
    wr(CTRL_OFF, 32'h8);
    rdc("dis count after", COUNT_OFF, 32'd5);
    tick(4);
    rdc("dis count held", COUNT_OFF, 32'd5);
    check("dis irq", {31'd0, irq}, 32'd0);
    wr(CTRL_OFF, 32'h9);
    tick(2);
    rdc("dis reload", COUNT_OFF, 32'd10);

    // PRESET = 0 acts like PRESET = 1: INT at E3, irq at E4
    do_reset();
    wr(CTRL_OFF, 32'h9);
    tick(2);
    rdc("p0 count E2", COUNT_OFF, 32'd0);
    check("p0 irq E2", {31'd0, irq}, 32'd0);
    tick(2);
    check("p0 irq E4", {31'd0, irq}, 32'd1);

    // CTRL write during the INT cycle, PRESET = 2
    do_reset();
    wr(PRESET_OFF, 32'd2);
    wr(CTRL_OFF, 32'h9);
    tick(4);
    rdc("intw count", COUNT_OFF, 32'd0);
    wr(CTRL_OFF, 32'h8);
    check("intw irq", {31'd0, irq}, 32'd0);
    rdc("intw ctrl", CTRL_OFF, 32'h8);
    tick();
    check("intw irq2", {31'd0, irq}, 32'd0);

    // async reset while a reload pulse is high
    do_reset();
    wr(PRESET_OFF, 32'd5);
    wr(CTRL_OFF, 32'hB);
    tick(8);
    check("mid irq E8", {31'd0, irq}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid rst irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++)
      rdc($sformatf("mid rst rdata%0d", a), 2'(a), 32'd0);
    reset = 1'b1;
    tick();
    rdc("post rst count", COUNT_OFF, 32'd0);
    tick(3);
    rdc("post rst idle", COUNT_OFF, 32'd0);
    check("post rst irq", {31'd0, irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
